fdd_wprecomp: RTL and testbench
===============================

FDD_WPRECOMP -- requirements
Module: fdd_wprecomp

Interface
REQ-001 SHALL have parameter SHIFT_TICKS, default 2, giving precompensation shift in clk14 cycles (range 0..7).
REQ-002 SHALL have parameter PULSE_TICKS, default 7, giving the fd_wdat_n low-pulse width in clk14 cycles (range 1..15).
REQ-003 SHALL have parameter TR43_ONLY, default 1; when 1, precompensation applies only while vg_tr43=1, and when 0 it always applies.
REQ-004 SHALL have parameter RD_STRETCH, default 4, giving the vg_rawr high width in clk14 cycles (range 1..15).
REQ-005 SHALL have port clk14, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-007 SHALL have port en, input, 1 bit: the block enable.
REQ-008 SHALL have ports vg_wd, vg_sl, vg_sr and vg_tr43, input, 1 bit each: the asynchronous WD1793 write data, early, late and track-43 signals.
REQ-009 SHALL have port fd_rdat, input, 1 bit: the asynchronous active-low drive read data.
REQ-010 SHALL have port fd_wdat_n, output, 1 bit: the active-low write data to the drive.
REQ-011 SHALL have port vg_rawr, output, 1 bit: the active-high stretched read pulse to the WD1793.
REQ-012 SHALL have port busy, output, 1 bit: high while the write FSM is not in IDLE.
REQ-013 SHALL have port overrun, output, 1 bit: a one-cycle pulse when a write edge is dropped.

Function
REQ-014 SHALL synchronise vg_wd, vg_sl, vg_sr, vg_tr43 and fd_rdat through two flops each, then register once more for edge detection.
REQ-015 SHALL define write-edge detection as synchronised vg_wd going 0->1; call the first clk14 edge sampling vg_wd=1 "edge 0". The detect SHALL occur at edge 2.
REQ-016 SHALL latch the shift class on detect:
- EARLY (delay 0) when sl=1, sr=0 and the gate is true.
- LATE (delay 2*SHIFT_TICKS) when sr=1, sl=0 and the gate is true.
- Otherwise NOMINAL (delay SHIFT_TICKS).
- The gate is (vg_tr43 | ~TR43_ONLY).
REQ-017 SHALL treat sl=sr=1 as NOMINAL.
REQ-018 SHALL implement the write FSM as IDLE -> DELAY -> PULSE -> IDLE:
- DELAY is skipped when the latched delay is 0.
- fd_wdat_n is 0 only in PULSE.
REQ-019 SHALL drive fd_wdat_n low from edge 3+D through edge 3+D+PULSE_TICKS-1, where D is the latched delay, giving exactly PULSE_TICKS cycles low.
REQ-020 SHALL ignore a write edge detected while the FSM is in DELAY or PULSE, and pulse overrun for 1 cycle at detect; the pulse in progress is unaffected.
REQ-021 SHALL accept a write edge detected in the same cycle the FSM returns to IDLE.
REQ-022 SHALL size the shared down-counter to $clog2(2*SHIFT_TICKS+PULSE_TICKS+1) bits; it never wraps.
REQ-023 SHALL define a read edge as synchronised fd_rdat going 1->0; it sets vg_rawr=1 for RD_STRETCH cycles starting the cycle after detect.
REQ-024 SHALL retrigger on a new read edge while vg_rawr=1, reloading the counter so vg_rawr stays high continuously.
REQ-025 SHALL handle en=0 as follows:
- The write FSM goes to IDLE at the next edge.
- fd_wdat_n=1, overrun=0, no edge is accepted.
- The read path keeps running.
REQ-026 SHALL leave the read and write paths independent, so simultaneous read and write edges are both processed.

Reset
REQ-027 SHALL, on rst_n=0, immediately hold fd_wdat_n=1, vg_rawr=0, busy=0 and overrun=0, with the FSM in IDLE, counters at 0 and all sync flops at idle levels (vg_* 0, fd_rdat 1).
REQ-028 SHALL abort a pulse in progress on reset mid-operation, and generate no pulse after release until a new edge is detected.

Structure
REQ-029 SHALL place FSM state encodings and the shift-class encodings in a shared package/include, fdd_pkg.
REQ-030 SHALL use one sub-module, fdd_sync (2-flop synchroniser, width parameter), instantiated for all async inputs.
REQ-031 SHALL be implemented in 120-400 lines of RTL.

Verification (defaults, TR43_ONLY=1)
REQ-032 SHALL cover: vg_wd pulse with sl=sr=tr43=0 -> fd_wdat_n low at edges 5..11 (7 cycles), busy high 2 cycles before.
REQ-033 SHALL cover: tr43=1, sl=1 -> fd_wdat_n low at edges 3..9; tr43=1, sr=1 -> low at edges 7..13; tr43=0, sr=1 -> edges 5..11.
REQ-034 SHALL cover: second vg_wd rising 4 cycles after the first -> overrun single pulse, exactly one 7-cycle low pulse.
REQ-035 SHALL cover: fd_rdat low 2 cycles -> vg_rawr high 4 cycles; a second falling edge 3 cycles later -> vg_rawr high continuously for 7 cycles.
REQ-036 SHALL cover: rst_n asserted mid-PULSE -> fd_wdat_n=1 immediately, busy=0; after release with no edge -> no pulse.
REQ-037 SHALL cover: en=0 during DELAY -> no pulse, busy=0 next cycle; read pulses still stretched.

Source files
------------

// File: rtl/fdd_pkg.sv
// Shared encodings for the floppy write-precompensation block:
// write FSM states and shift classes.
package fdd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    SH_NOM   = 2'd0,
    SH_EARLY = 2'd1,
    SH_LATE  = 2'd2
  } shift_e;

  function automatic int unsigned shift_delay(
    input shift_e      cls,
    input int unsigned ticks
  );
    unique case (cls)
      SH_EARLY: return 0;
      SH_LATE:  return 2 * ticks;
      default:  return ticks;
    endcase
  endfunction

endpackage

// File: rtl/fdd_sync.sv
// Two-flop synchroniser with a per-bit reset level so
// idle-high inputs come out of reset at their idle value.
module fdd_sync #(
  parameter int             W   = 1,
  parameter logic [W-1:0]   RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RST;
      s2_q <= RST;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/fdd_wprecomp.sv
// WD1793 write precompensation and read-pulse stretcher
// for a 14 MHz floppy interface.
module fdd_wprecomp
  import fdd_pkg::*;
#(
  parameter int SHIFT_TICKS = 2,
  parameter int PULSE_TICKS = 7,
  parameter int TR43_ONLY   = 1,
  parameter int RD_STRETCH  = 4
) (
  input  logic clk14,
  input  logic rst_n,
  input  logic en,
  input  logic vg_wd,
  input  logic vg_sl,
  input  logic vg_sr,
  input  logic vg_tr43,
  input  logic fd_rdat,
  output logic fd_wdat_n,
  output logic vg_rawr,
  output logic busy,
  output logic overrun
);

  localparam int CW = $clog2(2 * SHIFT_TICKS + PULSE_TICKS + 1);
  localparam int RW = $clog2(RD_STRETCH + 1);

  localparam logic [CW-1:0] PLOAD = CW'(PULSE_TICKS - 1);
  localparam logic [RW-1:0] RLOAD = RW'(RD_STRETCH);

  logic [4:0] sync;
  logic       wd_s, sl_s, sr_s, tr_s, rd_s;
  logic       wd_q, rd_q;
  logic       det_w, det_r;
  logic       gate;
  logic       accept;
  shift_e     cls;
  logic [CW-1:0] dly;

  wr_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;

  // fd_rdat idles high, everything else idles low
  fdd_sync #(
    .W   (5),
    .RST (5'b10000)
  ) u_sync (
    .clk   (clk14),
    .rst_n (rst_n),
    .d     ({fd_rdat, vg_tr43, vg_sr, vg_sl, vg_wd}),
    .q     (sync)
  );

  assign wd_s = sync[0];
  assign sl_s = sync[1];
  assign sr_s = sync[2];
  assign tr_s = sync[3];
  assign rd_s = sync[4];

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= 1'b0;
      rd_q <= 1'b1;
    end else begin
      wd_q <= wd_s;
      rd_q <= rd_s;
    end
  end

  assign det_w = wd_s & ~wd_q;
  assign det_r = ~rd_s & rd_q;
  assign gate  = tr_s | (TR43_ONLY == 0);

  always_comb begin
    cls = SH_NOM;
    unique case (1'b1)
      gate && sl_s && !sr_s: cls = SH_EARLY;
      gate && sr_s && !sl_s: cls = SH_LATE;
      default:               cls = SH_NOM;
    endcase
  end

  assign dly = CW'(shift_delay(cls, SHIFT_TICKS));

  // the last PULSE cycle hands over to IDLE, so a detect there is taken
  assign accept = en & det_w &
                  ((state_q == ST_IDLE) |
                   ((state_q == ST_PULSE) & (cnt_q == '0)));

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      if (dly == '0) begin
        state_d = ST_PULSE;
        cnt_d   = PLOAD;
      end else begin
        state_d = ST_DELAY;
        cnt_d   = dly - CW'(1);
      end
    end else begin
      unique case (state_q)
        ST_DELAY: begin
          if (cnt_q == '0) begin
            state_d = ST_PULSE;
            cnt_d   = PLOAD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_PULSE: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fd_wdat_n = ~(en & (state_q == ST_PULSE));
    busy      = (state_q != ST_IDLE);
    overrun   = en & det_w & ~accept;
  end

  // read stretcher reloads on every falling edge
  always_comb begin
    rcnt_d = rcnt_q;
    if (det_r) begin
      rcnt_d = RLOAD;
    end else if (rcnt_q != '0) begin
      rcnt_d = rcnt_q - RW'(1);
    end
  end

  assign vg_rawr = (rcnt_q != '0);

endmodule

// File: tb/tb_fdd_wprecomp.sv
// Scoreboard bench: expected output runs are queued by the
// stimulus and matched by a negedge monitor.
module tb_fdd_wprecomp;

  logic clk14 = 1'b0;
  logic rst_n;
  logic en;
  logic vg_wd, vg_sl, vg_sr, vg_tr43;
  logic fd_rdat;
  logic fd_wdat_n, vg_rawr, busy, overrun;

  typedef struct {
    int s;
    int l;
  } ev_t;

  ev_t wq[$];
  ev_t bq[$];
  ev_t rq[$];
  ev_t oq[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int k0;

  logic [3:0] cur;
  logic [3:0] prv = 4'b0;
  int         st[4];

  fdd_wprecomp dut (
    .clk14     (clk14),
    .rst_n     (rst_n),
    .en        (en),
    .vg_wd     (vg_wd),
    .vg_sl     (vg_sl),
    .vg_sr     (vg_sr),
    .vg_tr43   (vg_tr43),
    .fd_rdat   (fd_rdat),
    .fd_wdat_n (fd_wdat_n),
    .vg_rawr   (vg_rawr),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk14 = ~clk14;

  always @(posedge clk14) cyc++;

  function automatic string nm(input int k);
    case (k)
      0:       return "wdat_pulse";
      1:       return "busy";
      2:       return "rawr";
      default: return "overrun";
    endcase
  endfunction

  task automatic expect_run(input int k, input int s, input int l);
    ev_t e;
    e.s = s;
    e.l = l;
    case (k)
      0:       wq.push_back(e);
      1:       bq.push_back(e);
      2:       rq.push_back(e);
      default: oq.push_back(e);
    endcase
  endtask

  task automatic got(input int k, input int s, input int l);
    ev_t e;
    bit  have;
    have = 1'b0;
    e.s  = 0;
    e.l  = 0;
    case (k)
      0: if (wq.size() > 0) begin e = wq.pop_front(); have = 1'b1; end
      1: if (bq.size() > 0) begin e = bq.pop_front(); have = 1'b1; end
      2: if (rq.size() > 0) begin e = rq.pop_front(); have = 1'b1; end
      default:
         if (oq.size() > 0) begin e = oq.pop_front(); have = 1'b1; end
    endcase
    n_chk++;
    if (!have) begin
      n_fail++;
      $display("FAIL %s: unexpected run start %0d len %0d, required none",
               nm(k), s, l);
    end else if (e.s != s || e.l != l) begin
      n_fail++;
      $display("FAIL %s: got start %0d len %0d, required start %0d len %0d",
               nm(k), s, l, e.s, e.l);
    end
  endtask

  // active-high view of each output; a completed run is scored
  always @(negedge clk14) begin
    cur = {overrun, vg_rawr, busy, ~fd_wdat_n};
    for (int k = 0; k < 4; k++) begin
      int kk;
      kk = (k == 2) ? 2 : (k == 3) ? 3 : k;
      if (cur[k] && !prv[k]) st[k] = cyc;
      if (!cur[k] && prv[k]) got(kk, st[k], cyc - st[k]);
    end
    prv = cur;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk14);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic a, input logic r);
    n_chk++;
    if (a !== r) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, a, r);
    end
  endtask

  task automatic chk_empty(input string name, input int sz);
    n_chk++;
    if (sz != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected runs never seen, required 0",
               name, sz);
    end
  endtask

  task automatic wr(input logic sl, input logic sr, input logic tr,
                    input int d);
    step();
    k0      = cyc;
    vg_wd   = 1'b1;
    vg_sl   = sl;
    vg_sr   = sr;
    vg_tr43 = tr;
    expect_run(0, k0 + 3 + d, 7);
    expect_run(1, k0 + 3, d + 7);
    step(2);
    vg_wd = 1'b0;
    step(18);
    vg_sl   = 1'b0;
    vg_sr   = 1'b0;
    vg_tr43 = 1'b0;
    step(4);
  endtask

  initial begin
    rst_n   = 1'b1;
    en      = 1'b1;
    vg_wd   = 1'b0;
    vg_sl   = 1'b0;
    vg_sr   = 1'b0;
    vg_tr43 = 1'b0;
    fd_rdat = 1'b1;
    #1 rst_n = 1'b0;
    step(2);
    chk("rst_wdat_n", fd_wdat_n, 1'b1);
    chk("rst_rawr", vg_rawr, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    step(3);

    wr(1'b0, 1'b0, 1'b0, 2);
    wr(1'b1, 1'b0, 1'b1, 0);
    wr(1'b0, 1'b1, 1'b1, 4);
    wr(1'b0, 1'b1, 1'b0, 2);
    wr(1'b1, 1'b1, 1'b1, 2);

    step();
    k0    = cyc;
    vg_wd = 1'b1;
    expect_run(0, k0 + 5, 7);
    expect_run(1, k0 + 3, 9);
    expect_run(3, k0 + 6, 1);
    step(2);
    vg_wd = 1'b0;
    step(2);
    vg_wd = 1'b1;
    step(2);
    vg_wd = 1'b0;
    step(20);

    step();
    k0      = cyc;
    fd_rdat = 1'b0;
    expect_run(2, k0 + 3, 4);
    step(2);
    fd_rdat = 1'b1;
    step(10);

    step();
    k0      = cyc;
    fd_rdat = 1'b0;
    expect_run(2, k0 + 3, 7);
    step(2);
    fd_rdat = 1'b1;
    step(1);
    fd_rdat = 1'b0;
    step(2);
    fd_rdat = 1'b1;
    step(15);

    step();
    k0      = cyc;
    vg_wd   = 1'b1;
    fd_rdat = 1'b0;
    expect_run(0, k0 + 5, 7);
    expect_run(1, k0 + 3, 9);
    expect_run(2, k0 + 3, 4);
    step(2);
    vg_wd   = 1'b0;
    fd_rdat = 1'b1;
    step(20);

    step();
    k0      = cyc;
    vg_wd   = 1'b1;
    fd_rdat = 1'b0;
    expect_run(1, k0 + 3, 1);
    expect_run(2, k0 + 3, 4);
    step(2);
    vg_wd   = 1'b0;
    fd_rdat = 1'b1;
    step(1);
    chk("busy_in_delay", busy, 1'b1);
    en = 1'b0;
    #1;
    chk("en0_wdat_n", fd_wdat_n, 1'b1);
    step(1);
    chk("en0_busy_next", busy, 1'b0);
    step(15);
    en = 1'b1;
    step(5);

    step();
    k0    = cyc;
    vg_wd = 1'b1;
    expect_run(0, k0 + 5, 2);
    expect_run(1, k0 + 3, 4);
    step(2);
    vg_wd = 1'b0;
    step(3);
    chk("pre_rst_wdat_n", fd_wdat_n, 1'b0);
    step(1);
    rst_n = 1'b0;
    #1;
    chk("midrst_wdat_n", fd_wdat_n, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_overrun", overrun, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(20);

    step(5);
    chk_empty("wdat_pulse_q", wq.size());
    chk_empty("busy_q", bq.size());
    chk_empty("rawr_q", rq.size());
    chk_empty("overrun_q", oq.size());

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
